// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: bubble-payload policy constants and occupancy-width helper for pipe_valid_reg
package core_pipe_pkg;
  localparam bit BUBBLE_ZERO = 1'b1;
  localparam bit BUBBLE_KEEP = 1'b0;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_valid_reg_if.sv
// pipe_valid_reg_if: enable/flush/flush_mask/in_valid/in_data from master; out_valid/out_data/occupancy/bubble_cnt from slave
interface pipe_valid_reg_if import core_pipe_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
);
  logic enable;
  logic flush;
  logic [DEPTH-1:0] flush_mask;
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [occ_w(DEPTH)-1:0] occupancy;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output enable, flush, flush_mask, in_valid, in_data,
    input out_valid, out_data, occupancy, bubble_cnt
  );
  modport slave (
    input enable, flush, flush_mask, in_valid, in_data,
    output out_valid, out_data, occupancy, bubble_cnt
  );
endinterface

// File: rtl/pipe_valid_stage.sv
// pipe_valid_stage: one valid+payload register; load shifts in, else holds; kill clears valid; zero forces RESET_VALUE into invalid slots
module pipe_valid_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic kill,
  input  logic zero,
  input  logic in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic valid,
  output logic [WIDTH-1:0] data
);
  logic nv;
  logic [WIDTH-1:0] nd;
  always_comb begin
    nv = !kill && (load ? in_valid : valid);
    nd = (zero && !nv) ? RESET_VALUE : (load ? in_data : data);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data <= RESET_VALUE;
    end else begin
      valid <= nv;
      data <= nd;
    end
  end
endmodule

// File: rtl/pipe_valid_reg.sv
// pipe_valid_reg: DEPTH-stage valid-tracked delay line (clk, rst, bus slave) with kill, occupancy popcount and saturating bubble counter
module pipe_valid_reg import core_pipe_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit ZERO_ON_BUBBLE = BUBBLE_ZERO,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_valid_reg_if.slave bus
);
  localparam int OW = occ_w(DEPTH);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] pv;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] pd [DEPTH];
  logic [OW-1:0] occ;
  logic [CNT_W-1:0] cnt;
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_valid_reg: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_valid_reg: WIDTH must be >= 1");
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign pv[k] = bus.in_valid;
      assign pd[k] = bus.in_data;
    end else begin : g_body
      assign pv[k] = v[k-1];
      assign pd[k] = d[k-1];
    end
    pipe_valid_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
      .clk(clk),
      .rst(rst),
      .load(bus.enable),
      .kill(bus.flush | bus.flush_mask[k]),
      .zero(ZERO_ON_BUBBLE),
      .in_valid(pv[k]),
      .in_data(pd[k]),
      .valid(v[k]),
      .data(d[k])
    );
  end
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OW'(v[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (bus.enable && !v[DEPTH-1] && cnt != '1) cnt <= cnt + CNT_W'(1);
  end
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data = d[DEPTH-1];
  assign bus.occupancy = occ;
  assign bus.bubble_cnt = cnt;
endmodule

// File: tb/tb_pipe_valid_reg.sv
// tb_pipe_valid_reg: scoreboarded random+directed bench for two DEPTH=3 instances (zeroing/16-bit counter and keeping/4-bit counter)
module tb_pipe_valid_reg;
  import core_pipe_pkg::*;
  typedef struct {
    logic v;
    logic [31:0] d;
    logic [31:0] occ;
    logic [31:0] cnt;
  } exp_t;
  logic clk;
  logic rst;
  int total = 0;
  int bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic mv [2][3];
  logic [31:0] md [2][3];
  int mc [2];
  pipe_valid_reg_if #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) b0 ();
  pipe_valid_reg_if #(.WIDTH(32), .DEPTH(3), .CNT_W(4)) b1 ();
  pipe_valid_reg #(.WIDTH(32), .DEPTH(3), .RESET_VALUE('0), .ZERO_ON_BUBBLE(BUBBLE_ZERO), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  pipe_valid_reg #(.WIDTH(32), .DEPTH(3), .RESET_VALUE('0), .ZERO_ON_BUBBLE(BUBBLE_KEEP), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model(input logic r, input logic e, input logic f, input logic [2:0] m, input logic iv, input logic [31:0] id);
    for (int j = 0; j < 2; j++) begin
      int cmax;
      int occ;
      exp_t x;
      cmax = (j == 0) ? 65535 : 15;
      if (r) begin
        for (int k = 0; k < 3; k++) begin
          mv[j][k] = 1'b0;
          md[j][k] = '0;
        end
        mc[j] = 0;
      end else begin
        if (e && !mv[j][2] && mc[j] < cmax) mc[j]++;
        if (e) begin
          for (int k = 2; k > 0; k--) begin
            mv[j][k] = mv[j][k-1];
            md[j][k] = md[j][k-1];
          end
          mv[j][0] = iv;
          md[j][0] = id;
        end
        for (int k = 0; k < 3; k++) begin
          if (f || m[k]) mv[j][k] = 1'b0;
          if (j == 0 && !mv[j][k]) md[j][k] = '0;
        end
      end
      occ = 0;
      for (int k = 0; k < 3; k++) occ += int'(mv[j][k]);
      x.v = mv[j][2];
      x.d = md[j][2];
      x.occ = occ;
      x.cnt = mc[j];
      if (j == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic f, input logic [2:0] m, input logic iv, input logic [31:0] id);
    @(negedge clk);
    rst = r;
    b0.enable = e; b0.flush = f; b0.flush_mask = m; b0.in_valid = iv; b0.in_data = id;
    b1.enable = e; b1.flush = f; b1.flush_mask = m; b1.in_valid = iv; b1.in_data = id;
    @(posedge clk);
    model(r, e, f, m, iv, id);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q0.size() != 0) begin
        x = q0.pop_front();
        cmp("u0_out_valid", 32'(b0.out_valid), 32'(x.v));
        cmp("u0_out_data", b0.out_data, x.d);
        cmp("u0_occupancy", 32'(b0.occupancy), x.occ);
        cmp("u0_bubble_cnt", 32'(b0.bubble_cnt), x.cnt);
      end
      if (q1.size() != 0) begin
        x = q1.pop_front();
        cmp("u1_out_valid", 32'(b1.out_valid), 32'(x.v));
        cmp("u1_out_data", b1.out_data, x.d);
        cmp("u1_occupancy", 32'(b1.occupancy), x.occ);
        cmp("u1_bubble_cnt", 32'(b1.bubble_cnt), x.cnt);
      end
    end
  end
  initial begin
    rst = 1'b1;
    b0.enable = 0; b0.flush = 0; b0.flush_mask = '0; b0.in_valid = 0; b0.in_data = '0;
    b1.enable = 0; b1.flush = 0; b1.flush_mask = '0; b1.in_valid = 0; b1.in_data = '0;
    repeat (2) step(1, 1, 0, 3'b000, 1, 32'hFFFFFFFF);
    step(0, 1, 0, 3'b000, 1, 32'hA1A1A1A1);
    step(0, 1, 0, 3'b000, 1, 32'hA2A2A2A2);
    step(0, 1, 0, 3'b000, 1, 32'hA3A3A3A3);
    repeat (4) step(0, 0, 0, 3'b000, 1, 32'hBBBBBBBB);
    repeat (3) step(0, 1, 0, 3'b000, 0, 32'h0);
    step(0, 1, 0, 3'b000, 1, 32'hC1C1C1C1);
    step(0, 1, 0, 3'b000, 1, 32'hC2C2C2C2);
    step(0, 1, 0, 3'b000, 1, 32'hC3C3C3C3);
    step(0, 1, 0, 3'b100, 0, 32'h0);
    repeat (2) step(0, 1, 0, 3'b000, 0, 32'h0);
    step(0, 1, 0, 3'b000, 1, 32'hD1D1D1D1);
    step(0, 1, 0, 3'b000, 1, 32'hD2D2D2D2);
    step(0, 1, 0, 3'b000, 1, 32'hD3D3D3D3);
    step(0, 0, 1, 3'b000, 1, 32'hEEEEEEEE);
    repeat (20) step(0, 1, 0, 3'b000, 0, 32'h0);
    repeat (3) step(0, 1, 0, 3'b000, 0, 32'h12345678);
    step(0, 0, 0, 3'b010, 0, 32'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
           3'($urandom_range(7) & $urandom_range(7)), $urandom_range(9) < 7, $urandom);
    repeat (2) @(negedge clk);
    cmp("q0_drained", q0.size(), 0);
    cmp("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
